// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI execution-unit link
package spi_pkg;

  localparam int OP_W   = 8;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TURN,
    RX,
    DONE
  } spi_mst_state_t;

  // Opcodes decoded by the ALU, multiplier and barrel-shifter slaves
  localparam logic [OP_W-1:0] OP_ADD = 8'hA5;
  localparam logic [OP_W-1:0] OP_SUB = 8'hA6;
  localparam logic [OP_W-1:0] OP_AND = 8'hA8;
  localparam logic [OP_W-1:0] OP_OR  = 8'hA9;
  localparam logic [OP_W-1:0] OP_XOR = 8'hAA;
  localparam logic [OP_W-1:0] OP_MUL = 8'hB1;
  localparam logic [OP_W-1:0] OP_SHL = 8'hC2;
  localparam logic [OP_W-1:0] OP_SHR = 8'hC3;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCLK divider with edge strobes for the SPI master FSM
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes flag the system edge on which sclk is about to toggle
  assign wrap     = en && (div_cnt == DIV_MAX);
  assign rise_stb = wrap && !sclk;
  assign fall_stb = wrap && sclk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - command-frame SPI master: opcode + two operands out, one result in
module spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int OP_W      = spi_pkg::OP_W,
  parameter int DATA_W    = spi_pkg::DATA_W,
  parameter int TURN_BITS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  import spi_pkg::*;

  localparam int N_TX  = OP_W + 2 * DATA_W;
  localparam int N_ALL = N_TX + TURN_BITS + DATA_W;
  localparam int CNT_W = $clog2(N_ALL + 1);

  localparam logic [CNT_W-1:0] LAST_TX   = CNT_W'(N_TX - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(N_TX + TURN_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_RX   = CNT_W'(N_ALL - 1);

  spi_mst_state_t    state, state_nxt;
  logic [N_TX-1:0]   tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              clk_en;
  logic              accept;
  logic              rise_stb;
  logic              fall_stb;

  assign clk_en = (state == TX) || (state == TURN) || (state == RX);
  // DONE behaves like IDLE so a held start yields back-to-back frames
  assign accept = start && ((state == IDLE) || (state == DONE));

  spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clock    (clock),
    .reset    (reset),
    .en       (clk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = accept ? TX : IDLE;
      end
      TX: begin
        if (fall_stb && (bit_cnt == LAST_TX)) begin
          state_nxt = (TURN_BITS == 0) ? RX : TURN;
        end
      end
      TURN: begin
        if (fall_stb && (bit_cnt == LAST_TURN)) begin
          state_nxt = RX;
        end
      end
      RX: begin
        if (fall_stb && (bit_cnt == LAST_RX)) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Slot boundaries are the sclk falling edges; miso is taken on the rising edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      result  <= '0;
    end else begin
      if (accept) begin
        tx_sr <= {opcode, op_a, op_b};
      end else if (fall_stb) begin
        tx_sr <= {tx_sr[N_TX-2:0], 1'b0};
      end

      if (!clk_en) begin
        bit_cnt <= '0;
      end else if (fall_stb) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (rise_stb && (state == RX)) begin
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end

      if ((state == RX) && (state_nxt == DONE)) begin
        result <= rx_sr;
      end
    end
  end

  assign busy = clk_en;
  assign cs_n = !clk_en;
  assign done = (state == DONE);
  assign mosi = (state == TX) && tx_sr[N_TX-1];

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  import spi_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start0, start1;
  logic [7:0]  opcode0, opcode1;
  logic [31:0] op_a0, op_b0, op_a1, op_b1;
  logic        busy0, done0, sclk0, cs_n0, mosi0, miso0;
  logic        busy1, done1, sclk1, cs_n1, mosi1, miso1;
  logic [31:0] result0, result1;

  spi_master u_dut0 (
    .clock (clock), .reset (reset), .start (start0), .opcode (opcode0),
    .op_a (op_a0), .op_b (op_b0), .busy (busy0), .done (done0),
    .result (result0), .sclk (sclk0), .cs_n (cs_n0), .mosi (mosi0), .miso (miso0)
  );

  spi_master #(.CLK_DIV (1)) u_dut1 (
    .clock (clock), .reset (reset), .start (start1), .opcode (opcode1),
    .op_a (op_a1), .op_b (op_b1), .busy (busy1), .done (done1),
    .result (result1), .sclk (sclk1), .cs_n (cs_n1), .mosi (mosi1), .miso (miso1)
  );

  function automatic logic [31:0] slave_fn(input logic [71:0] f);
    logic [31:0] a, b;
    a = f[63:32];
    b = f[31:0];
    case (f[71:64])
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Mode-0 slaves sampled mid-cycle: capture on sclk rise, drive on sclk fall
  logic [71:0] cap0, cap1;
  logic [31:0] resp0, resp1;
  logic        sclk0_q = 1'b0, sclk1_q = 1'b0;
  int          rises0, falls0, rises1, falls1;

  always @(negedge clock) begin
    if (cs_n0) begin
      rises0 = 0; falls0 = 0; miso0 = 1'b0;
    end else begin
      if (sclk0 && !sclk0_q) begin
        if (rises0 < 72) cap0 = {cap0[70:0], mosi0};
        rises0++;
      end
      if (!sclk0 && sclk0_q) begin
        falls0++;
        if (falls0 == 72) resp0 = slave_fn(cap0);
        if (falls0 >= 74 && falls0 < 106) miso0 = resp0[31-(falls0-74)];
      end
    end
    sclk0_q = sclk0;
  end

  always @(negedge clock) begin
    if (cs_n1) begin
      rises1 = 0; falls1 = 0; miso1 = 1'b0;
    end else begin
      if (sclk1 && !sclk1_q) begin
        if (rises1 < 72) cap1 = {cap1[70:0], mosi1};
        rises1++;
      end
      if (!sclk1 && sclk1_q) begin
        falls1++;
        if (falls1 == 72) resp1 = slave_fn(cap1);
        if (falls1 >= 74 && falls1 < 106) miso1 = resp1[31-(falls1-74)];
      end
    end
    sclk1_q = sclk1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full default-divider frame on dut0; optional start re-pulse mid-frame
  task automatic frame0(input string tag, input logic [7:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input int repulse_at, input logic [31:0] exp_res);
    int cyc, done_cnt, done_at, csn_low;
    logic [31:0] res_at;
    logic [2:0]  done_pins;
    opcode0 = opc; op_a0 = a; op_b0 = b; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    cyc = 1; done_cnt = 0; done_at = 0; csn_low = 0; res_at = '0; done_pins = '0;
    check({tag, "_busy_t1"}, busy0, 1);
    check({tag, "_csn_t1"}, cs_n0, 0);
    check({tag, "_mosi_t1"}, mosi0, opc[7]);
    while (cyc < 900) begin
      if (done0) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = cyc; res_at = result0; done_pins = {cs_n0, busy0, sclk0};
        end
      end
      if (!cs_n0 && cyc <= 848) csn_low++;
      if (repulse_at != 0 && cyc == repulse_at) begin
        start0 = 1'b1; opcode0 = OP_SUB; op_a0 = 32'h1111_1111; op_b0 = 32'h2222_2222;
      end
      if (repulse_at != 0 && cyc == repulse_at + 1) start0 = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, 849);
    check({tag, "_result"}, res_at, exp_res);
    check({tag, "_done_pins"}, {29'd0, done_pins}, 32'd4);
    check({tag, "_csn_low_cycles"}, csn_low, 848);
    check({tag, "_tx_opcode"}, {24'd0, cap0[71:64]}, {24'd0, opc});
    check({tag, "_tx_op_a"}, cap0[63:32], a);
    check({tag, "_tx_op_b"}, cap0[31:0], b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, done_at, bad;
    logic [31:0] res_at;
    logic [7:0]  opcs [0:3];
    logic [31:0] as [0:3];
    logic [31:0] bs [0:3];
    logic [31:0] exps [0:3];

    reset = 1'b1;
    start0 = 1'b0; opcode0 = '0; op_a0 = '0; op_b0 = '0;
    start1 = 1'b0; opcode1 = '0; op_a1 = '0; op_b1 = '0;
    #12;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", result0, 0);
    check("rst_csn", cs_n0, 1);
    check("rst_sclk", sclk0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_csn_div1", cs_n1, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // 0xA5 gives mosi 1,0,1,0,0,1,0,1; 5 + 7 = 0xC
    frame0("basic", 8'hA5, 32'd5, 32'd7, 0, 32'h0000_000C);

    frame0("repulse", 8'hA5, 32'd5, 32'd7, 100, 32'h0000_000C);

    // Reset in cycle T0+300, checked before the next clock edge
    opcode0 = OP_ADD; op_a0 = 32'd9; op_b0 = 32'd9; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (299) @(posedge clock);
    #1;
    check("pre_reset_busy", busy0, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy0, 0);
    check("midrst_csn", cs_n0, 1);
    check("midrst_sclk", sclk0, 0);
    check("midrst_mosi", mosi0, 0);
    check("midrst_done", done0, 0);
    check("midrst_result", result0, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done0 || !cs_n0) bad++;
    end
    check("postrst_quiet", bad, 0);
    frame0("after_rst", OP_SUB, 32'd100, 32'd58, 0, 32'h0000_002A);

    // CLK_DIV=1: sclk toggles every cycle, done at T0+213
    opcode1 = 8'h3C; op_a1 = 32'h0F0F_0F0F; op_b1 = 32'h1234_5678; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    done_at = 0; res_at = '0; bad = 0;
    for (int c = 1; c < 250; c++) begin
      if (c <= 16 && sclk1 !== ((c % 2) == 0)) bad++;
      if (done1 && done_at == 0) begin done_at = c; res_at = result1; end
      @(posedge clock); #1;
    end
    check("div1_sclk_toggle", bad, 0);
    check("div1_done_cycle", done_at, 213);
    check("div1_result", res_at, 32'hDEADBEEF);
    check("div1_tx_op_b", cap1[31:0], 32'h1234_5678);

    // start held high: frames back to back, cs_n high for one cycle between
    opcs[0] = OP_ADD; as[0] = 32'd1;         bs[0] = 32'd2;         exps[0] = 32'h0000_0003;
    opcs[1] = OP_MUL; as[1] = 32'd3;         bs[1] = 32'h1000_0001; exps[1] = 32'h3000_0003;
    opcs[2] = OP_SUB; as[2] = 32'd10;        bs[2] = 32'd20;        exps[2] = 32'hFFFF_FFF6;
    opcs[3] = OP_ADD; as[3] = 32'hFFFF_FFFF; bs[3] = 32'd2;         exps[3] = 32'h0000_0001;
    opcode0 = opcs[0]; op_a0 = as[0]; op_b0 = bs[0]; start0 = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      while (!done0 && cnt < 1000) begin
        @(posedge clock); #1;
        cnt++;
      end
      check($sformatf("b2b%0d_frame_len", k), cnt, 848);
      check($sformatf("b2b%0d_result", k), result0, exps[k]);
      check($sformatf("b2b%0d_csn_gap", k), cs_n0, 1);
      opcode0 = opcs[k+1]; op_a0 = as[k+1]; op_b0 = bs[k+1];
      if (k == 2) start0 = 1'b0;
      @(posedge clock); #1;
      check($sformatf("b2b%0d_csn_after", k), cs_n0, (k == 2) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
